// File: rtl/riscv_store_tracer.sv
// Store-trace and end-of-test monitor: timestamps matching core stores into an FWFT FIFO
// and tracks the tohost pass/fail mailbox plus a cycle-budget timeout.
module riscv_store_tracer #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 16,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h0000_1000,
  parameter logic [ADDR_W-1:0] FILT_BASE   = '0,
  parameter logic [ADDR_W-1:0] FILT_MASK   = '0,
  parameter int                TIMEOUT     = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [31:0]              rd_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic [1:0]               status,
  output logic                     done,
  output logic [DATA_W-2:0]        fail_code,
  output logic [31:0]              cycle
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    PASS       = 2'b01,
    FAIL       = 2'b10,
    TIMED_OUT  = 2'b11
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0] mem_data  [DEPTH];
  logic [31:0]       mem_stamp [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          wr_wrap, rd_wrap;
  logic          running, tohost_hit, match, full, pop, push, drop, timeout_hit;

  // The wrap bits extend the pointers so full and empty are distinguishable.
  assign count    = {wr_wrap, wr_ptr} - {rd_wrap, rd_ptr};
  assign rd_valid = (count != '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign rd_addr  = mem_addr[rd_ptr];
  assign rd_data  = mem_data[rd_ptr];
  assign rd_stamp = mem_stamp[rd_ptr];

  assign running     = (state == RUN);
  assign tohost_hit  = wr_valid && (wr_addr == TOHOST_ADDR) && running;
  assign match       = wr_valid && ((wr_addr & FILT_MASK) == FILT_BASE) &&
                       (wr_addr != TOHOST_ADDR) && running;
  assign pop         = rd_valid && rd_ready;
  assign push        = match && (!full || pop);
  assign drop        = match && full && !pop;
  assign timeout_hit = (TIMEOUT != 0) && (cycle == TIMEOUT_LAST) && !tohost_hit && running;

  assign status = state;
  assign done   = (state != RUN);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr]  <= wr_addr;
      mem_data[wr_ptr]  <= wr_data;
      mem_stamp[wr_ptr] <= cycle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      fail_code <= '0;
      cycle     <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      wr_ptr    <= '0;
      wr_wrap   <= 1'b0;
      rd_ptr    <= '0;
      rd_wrap   <= 1'b0;
    end else begin
      if (push) {wr_wrap, wr_ptr} <= {wr_wrap, wr_ptr} + (PW+1)'(1);
      if (pop)  {rd_wrap, rd_ptr} <= {rd_wrap, rd_ptr} + (PW+1)'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      // The counter still advances on the triggering edge, so it freezes one past it.
      if (running && cycle != 32'hFFFF_FFFF) cycle <= cycle + 32'd1;
      case (state)
        RUN: begin
          if (tohost_hit) begin
            if (wr_data == DATA_W'(1)) begin
              state <= PASS;
            end else begin
              state     <= FAIL;
              fail_code <= wr_data[DATA_W-1:1];
            end
          end else if (timeout_hit) begin
            state <= TIMED_OUT;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_store_tracer.sv
// Directed bench for riscv_store_tracer: default, filtered and short-timeout instances
// share one stimulus stream; each scenario task checks its own expected values.
module tb_riscv_store_tracer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_ready = 1'b0;

  logic        rd_valid, overflow, done;
  logic [31:0] rd_addr, rd_data, rd_stamp, cycle;
  logic [4:0]  count;
  logic [15:0] drop_cnt;
  logic [1:0]  status;
  logic [30:0] fail_code;

  logic        f_rd_valid, f_overflow, f_done;
  logic [31:0] f_rd_addr, f_rd_data, f_rd_stamp, f_cycle;
  logic [4:0]  f_count;
  logic [15:0] f_drop_cnt;
  logic [1:0]  f_status;
  logic [30:0] f_fail_code;

  logic        t_rd_valid, t_overflow, t_done;
  logic [31:0] t_rd_addr, t_rd_data, t_rd_stamp, t_cycle;
  logic [4:0]  t_count;
  logic [15:0] t_drop_cnt;
  logic [1:0]  t_status;
  logic [30:0] t_fail_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_store_tracer dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_stamp(rd_stamp), .count(count), .overflow(overflow), .drop_cnt(drop_cnt),
    .status(status), .done(done), .fail_code(fail_code), .cycle(cycle)
  );

  riscv_store_tracer #(.FILT_BASE(32'h0000_2000), .FILT_MASK(32'h0000_F000)) dut_filt (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(f_rd_valid), .rd_ready(rd_ready), .rd_addr(f_rd_addr), .rd_data(f_rd_data),
    .rd_stamp(f_rd_stamp), .count(f_count), .overflow(f_overflow), .drop_cnt(f_drop_cnt),
    .status(f_status), .done(f_done), .fail_code(f_fail_code), .cycle(f_cycle)
  );

  riscv_store_tracer #(.TIMEOUT(64)) dut_to (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(t_rd_valid), .rd_ready(rd_ready), .rd_addr(t_rd_addr), .rd_data(t_rd_data),
    .rd_stamp(t_rd_stamp), .count(t_count), .overflow(t_overflow), .drop_cnt(t_drop_cnt),
    .status(t_status), .done(t_done), .fail_code(t_fail_code), .cycle(t_cycle)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_drop: got ovf=%0b cnt=%0d expected 0/0", overflow, drop_cnt); end
    checks++; if (status !== 2'b00 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_status: got %b/%0b expected 00/0", status, done); end
    checks++; if (cycle !== 32'd0 || fail_code !== 31'd0) begin errors++; $display("[TB] FAIL reset_cycle: got cycle=%0d fc=%0d expected 0/0", cycle, fail_code); end
  endtask

  task automatic test_basic();
    logic [31:0] ea [3];
    logic [31:0] ed [3];
    ea = '{32'h100, 32'h104, 32'h108};
    ed = '{32'hA, 32'hB, 32'hC};
    do_reset();
    step(5);
    checks++; if (cycle !== 32'd5) begin errors++; $display("[TB] FAIL basic_cycle5: got %0d expected 5", cycle); end
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_addr = ea[i];
      wr_data = ed[i];
      step();
    end
    wr_valid = 1'b0;
    checks++; if (count !== 5'd3) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 3", count); end
    checks++; if (rd_valid !== 1'b1 || rd_addr !== 32'h100 || rd_data !== 32'hA || rd_stamp !== 32'd5)
      begin errors++; $display("[TB] FAIL basic_head: got v=%0b %h/%h/%0d expected 1 00000100/0000000a/5", rd_valid, rd_addr, rd_data, rd_stamp); end
    step();
    checks++; if (rd_addr !== 32'h100 || count !== 5'd3) begin errors++; $display("[TB] FAIL basic_hold: got %h cnt=%0d expected 00000100 cnt=3", rd_addr, count); end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_addr !== ea[i] || rd_data !== ed[i] || rd_stamp !== 32'(5 + i)) begin
        errors++;
        $display("[TB] FAIL basic_pop%0d: got v=%0b %h/%h/%0d expected 1 %h/%h/%0d", i, rd_valid, rd_addr, rd_data, rd_stamp, ea[i], ed[i], 5 + i);
      end
      step();
    end
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("[TB] FAIL basic_empty: got v=%0b cnt=%0d expected 0/0", rd_valid, count); end
  endtask

  task automatic test_overflow();
    do_reset();
    wr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_addr = 32'h200 + 32'(4 * i);
      wr_data = 32'(i);
      step();
    end
    wr_valid = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 16", count); end
    checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd4) begin errors++; $display("[TB] FAIL ovf_drops: got ovf=%0b cnt=%0d expected 1/4", overflow, drop_cnt); end
    // Push and pop together on a full FIFO: heads 0..3 leave while 100..103 enter.
    rd_ready = 1'b1;
    wr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_addr = 32'h400 + 32'(4 * k);
      wr_data = 32'(100 + k);
      checks++; if (rd_data !== 32'(k)) begin errors++; $display("[TB] FAIL ovf_fullpop_head%0d: got %0d expected %0d", k, rd_data, k); end
      step();
      checks++; if (count !== 5'd16 || drop_cnt !== 16'd4) begin errors++; $display("[TB] FAIL ovf_fullpop%0d: got cnt=%0d drops=%0d expected 16/4", k, count, drop_cnt); end
    end
    wr_valid = 1'b0;
    for (int k = 4; k < 20; k++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== ((k < 16) ? 32'(k) : 32'(100 + k - 16))) begin
        errors++;
        $display("[TB] FAIL ovf_drain%0d: got v=%0b %0d expected 1 %0d", k, rd_valid, rd_data, (k < 16) ? k : 100 + k - 16);
      end
      step();
    end
    rd_ready = 1'b0;
    checks++; if (count !== 5'd0 || overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_end: got cnt=%0d ovf=%0b expected 0/1", count, overflow); end
  endtask

  task automatic test_filter();
    do_reset();
    store(32'h2004, 32'h11);
    store(32'h3004, 32'h22);
    step();
    checks++; if (f_count !== 5'd1) begin errors++; $display("[TB] FAIL filt_count: got %0d expected 1", f_count); end
    checks++; if (f_rd_addr !== 32'h2004 || f_rd_data !== 32'h11) begin errors++; $display("[TB] FAIL filt_head: got %h/%h expected 00002004/00000011", f_rd_addr, f_rd_data); end
    checks++; if (count !== 5'd2) begin errors++; $display("[TB] FAIL filt_unmasked: got %0d expected 2", count); end
  endtask

  task automatic test_pass();
    do_reset();
    step(50);
    store(32'h1000, 32'h1);
    checks++; if (status !== 2'b01 || done !== 1'b1) begin errors++; $display("[TB] FAIL pass_status: got %b/%0b expected 01/1", status, done); end
    checks++; if (cycle !== 32'd51) begin errors++; $display("[TB] FAIL pass_cycle: got %0d expected 51", cycle); end
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL pass_no_push: got %0d expected 0", count); end
    store(32'h300, 32'h5);
    store(32'h1000, 32'h7);
    step(3);
    checks++; if (count !== 5'd0 || cycle !== 32'd51 || status !== 2'b01) begin errors++; $display("[TB] FAIL pass_frozen: got cnt=%0d cycle=%0d st=%b expected 0/51/01", count, cycle, status); end
  endtask

  task automatic test_fail();
    do_reset();
    step(3);
    store(32'h1000, 32'h7);
    checks++; if (status !== 2'b10 || done !== 1'b1) begin errors++; $display("[TB] FAIL fail_status: got %b/%0b expected 10/1", status, done); end
    checks++; if (fail_code !== 31'd3) begin errors++; $display("[TB] FAIL fail_code: got %0d expected 3", fail_code); end
  endtask

  task automatic test_timeout();
    do_reset();
    step(63);
    checks++; if (t_cycle !== 32'd63 || t_status !== 2'b00) begin errors++; $display("[TB] FAIL to_before: got cycle=%0d st=%b expected 63/00", t_cycle, t_status); end
    step();
    checks++; if (t_status !== 2'b11 || t_done !== 1'b1 || t_cycle !== 32'd64) begin errors++; $display("[TB] FAIL to_fire: got st=%b done=%0b cycle=%0d expected 11/1/64", t_status, t_done, t_cycle); end
    checks++; if (status !== 2'b00) begin errors++; $display("[TB] FAIL to_default_off: got %b expected 00", status); end
    do_reset();
    step(63);
    store(32'h1000, 32'h1);
    checks++; if (t_status !== 2'b01) begin errors++; $display("[TB] FAIL to_tohost_wins: got %b expected 01", t_status); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) store(32'h500 + 32'(4 * i), 32'(i));
    store(32'h1000, 32'h1);
    checks++; if (count !== 5'd5 || status !== 2'b01) begin errors++; $display("[TB] FAIL rmid_pre: got cnt=%0d st=%b expected 5/01", count, status); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_fifo: got cnt=%0d v=%0b expected 0/0", count, rd_valid); end
    checks++; if (status !== 2'b00 || cycle !== 32'd0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL rmid_state: got st=%b cycle=%0d ovf=%0b expected 00/0/0", status, cycle, overflow); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_filter();
    test_pass();
    test_fail();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
